// File: rtl/cordic_pkg.sv
// Shared types and constants for the iterative rotation-mode CORDIC core.
package cordic_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ROTATE,
    DONE
  } state_t;

  // The arctan table is stored in Q4.12; other FracBits settings rescale it.
  localparam int LUT_FRAC = 12;

  // 1/K in Q4.12, the usual x0 pre-scale for unit-magnitude sin/cos output.
  localparam logic [15:0] KINV = 16'h09B7;

  // atan(2^-i) in Q4.12; entries past i=12 round to zero.
  function automatic logic [15:0] atan_lut(input logic [7:0] i);
    logic [15:0] v;
    case (i)
      8'd0:    v = 16'd3217;
      8'd1:    v = 16'd1899;
      8'd2:    v = 16'd1003;
      8'd3:    v = 16'd509;
      8'd4:    v = 16'd256;
      8'd5:    v = 16'd128;
      8'd6:    v = 16'd64;
      8'd7:    v = 16'd32;
      8'd8:    v = 16'd16;
      8'd9:    v = 16'd8;
      8'd10:   v = 16'd4;
      8'd11:   v = 16'd2;
      8'd12:   v = 16'd1;
      default: v = 16'd0;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/cordic_if.sv
// Start/operand/result bundle between a CORDIC client and the core.
interface cordic_if #(
  parameter int Width = 16
);
  logic                    start_cordic_i;
  logic signed [Width-1:0] x0_i;
  logic signed [Width-1:0] y0_i;
  logic signed [Width-1:0] z0_i;
  logic signed [Width-1:0] xn_o;
  logic signed [Width-1:0] yn_o;
  logic signed [Width-1:0] zn_o;
  logic                    done_tick_cordic_o;

  modport master (
    output start_cordic_i, x0_i, y0_i, z0_i,
    input  xn_o, yn_o, zn_o, done_tick_cordic_o
  );

  modport slave (
    input  start_cordic_i, x0_i, y0_i, z0_i,
    output xn_o, yn_o, zn_o, done_tick_cordic_o
  );
endinterface

// File: rtl/cordic_stage.sv
// One combinational CORDIC micro-rotation, steered by the sign of z.
module cordic_stage
  import cordic_pkg::*;
#(
  parameter int Width    = 16,
  parameter int FracBits = 12,
  parameter int CW       = 5
) (
  input  logic signed [Width+1:0] x_i,
  input  logic signed [Width+1:0] y_i,
  input  logic signed [Width-1:0] z_i,
  input  logic        [CW-1:0]    i_i,
  output logic signed [Width+1:0] x_o,
  output logic signed [Width+1:0] y_o,
  output logic signed [Width-1:0] z_o
);

  logic signed [Width+1:0] x_sh;
  logic signed [Width+1:0] y_sh;
  logic signed [Width-1:0] atan_raw;
  logic signed [Width-1:0] atan_w;

  assign x_sh     = x_i >>> i_i;
  assign y_sh     = y_i >>> i_i;
  assign atan_raw = Width'(atan_lut(8'(i_i)));

  if (FracBits >= LUT_FRAC) begin : g_lut_up
    assign atan_w = atan_raw <<< (FracBits - LUT_FRAC);
  end else begin : g_lut_down
    assign atan_w = atan_raw >>> (LUT_FRAC - FracBits);
  end

  // Rotate towards z = 0: negative z means d = -1.
  always_comb begin
    if (z_i[Width-1]) begin
      x_o = x_i + y_sh;
      y_o = y_i - x_sh;
      z_o = z_i + atan_w;
    end else begin
      x_o = x_i - y_sh;
      y_o = y_i + x_sh;
      z_o = z_i - atan_w;
    end
  end

endmodule

// File: rtl/cordic.sv
// Iterative rotation-mode CORDIC: FSM, iteration counter and x/y/z registers.
module cordic
  import cordic_pkg::*;
#(
  parameter int Width    = 16,
  parameter int FracBits = 12,
  parameter int Iter     = 16
) (
  input  logic      clk_i,
  input  logic      rst_i,
  cordic_if.slave   bus
);

  localparam int            CW   = $clog2(Width + 1);
  localparam logic [CW-1:0] LAST = CW'(Iter - 1);

  state_t state_q, state_d;
  logic [CW-1:0] i_q, i_d;
  logic signed [Width+1:0] x_q, x_d, y_q, y_d, x_nx, y_nx;
  logic signed [Width-1:0] z_q, z_d, z_nx;
  logic signed [Width-1:0] xn_q, yn_q, zn_q;
  logic done_q;
  logic load, rot, fin;

  cordic_stage #(.Width(Width), .FracBits(FracBits), .CW(CW)) u_stage (
    .x_i (x_q),
    .y_i (y_q),
    .z_i (z_q),
    .i_i (i_q),
    .x_o (x_nx),
    .y_o (y_nx),
    .z_o (z_nx)
  );

  // State register.
  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state and datapath control strobes.
  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    rot     = 1'b0;
    fin     = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start_cordic_i) begin
          load    = 1'b1;
          state_d = ROTATE;
        end
      end
      ROTATE: begin
        rot = 1'b1;
        if (i_q == LAST) state_d = DONE;
      end
      DONE: begin
        fin     = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Working-register next values: sign-extended load or one micro-rotation.
  always_comb begin
    x_d = x_q;
    y_d = y_q;
    z_d = z_q;
    i_d = i_q;
    if (load) begin
      x_d = {{2{bus.x0_i[Width-1]}}, bus.x0_i};
      y_d = {{2{bus.y0_i[Width-1]}}, bus.y0_i};
      z_d = bus.z0_i;
      i_d = '0;
    end else if (rot) begin
      x_d = x_nx;
      y_d = y_nx;
      z_d = z_nx;
      i_d = i_q + CW'(1);
    end
  end

  // Working registers and iteration counter.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      x_q <= '0;
      y_q <= '0;
      z_q <= '0;
      i_q <= '0;
    end else begin
      x_q <= x_d;
      y_q <= y_d;
      z_q <= z_d;
      i_q <= i_d;
    end
  end

  // Result registers: updated only on completion, done pulses alongside.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      xn_q   <= '0;
      yn_q   <= '0;
      zn_q   <= '0;
      done_q <= 1'b0;
    end else begin
      done_q <= fin;
      if (fin) begin
        xn_q <= x_q[Width-1:0];
        yn_q <= y_q[Width-1:0];
        zn_q <= z_q;
      end
    end
  end

  assign bus.xn_o               = xn_q;
  assign bus.yn_o               = yn_q;
  assign bus.zn_o               = zn_q;
  assign bus.done_tick_cordic_o = done_q;

endmodule

// File: tb/tb_cordic.sv
// Scoreboard bench for the CORDIC core: stimulus pushes expectations, a monitor checks results.
module tb_cordic;
  import cordic_pkg::*;

  localparam int W    = 16;
  localparam int IT   = 16;
  localparam int TOUT = 100;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  cordic_if #(.Width(W)) bus ();

  cordic #(.Width(W), .FracBits(12), .Iter(IT)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  typedef struct {
    string name;
    int    ex;
    int    ey;
    int    ez;
    int    tol;
  } exp_t;

  exp_t sb[$];
  int   n_chk    = 0;
  int   n_fail   = 0;
  int   done_cnt = 0;
  int   exp_done = 0;
  real  kgain;

  function automatic void chk(string nm, int act, int req, int tol);
    int diff;
    diff = act - req;
    if (diff < 0) diff = -diff;
    n_chk++;
    if (diff > tol) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (tol %0d)", nm, act, req, tol);
    end
  endfunction

  function automatic int rnd(real r);
    return (r >= 0.0) ? $rtoi(r + 0.5) : $rtoi(r - 0.5);
  endfunction

  // Monitor: every done tick pops one expectation and compares the results.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && bus.done_tick_cordic_o) begin
      done_cnt++;
      n_chk++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_done: got done tick with empty scoreboard, expected none");
      end else begin
        e = sb.pop_front();
        chk({e.name, ".xn"}, int'(bus.xn_o), e.ex, e.tol);
        chk({e.name, ".yn"}, int'(bus.yn_o), e.ey, e.tol);
        chk({e.name, ".zn"}, int'(bus.zn_o), e.ez, e.tol);
      end
    end
  end

  task automatic expect_res(string nm, int ex, int ey, int ez, int tol);
    exp_t e;
    e.name = nm; e.ex = ex; e.ey = ey; e.ez = ez; e.tol = tol;
    sb.push_back(e);
    exp_done++;
  endtask

  // One-cycle start; operands are scrambled afterwards since only the start edge matters.
  task automatic start_op(input logic [15:0] x0, input logic [15:0] y0, input logic [15:0] z0);
    @(posedge clk); #1;
    bus.start_cordic_i = 1'b1;
    bus.x0_i = x0; bus.y0_i = y0; bus.z0_i = z0;
    @(posedge clk); #1;
    bus.start_cordic_i = 1'b0;
    bus.x0_i = 16'($urandom); bus.y0_i = 16'($urandom); bus.z0_i = 16'($urandom);
  endtask

  task automatic wait_done(string nm, output int cyc);
    cyc = 0;
    do begin
      @(posedge clk); #1;
      cyc++;
    end while (!bus.done_tick_cordic_o && cyc < TOUT);
    chk({nm, ".done_within_budget"}, int'(bus.done_tick_cordic_o), 1, 0);
  endtask

  initial begin
    int cyc, d0, z;
    real zr;
    bus.start_cordic_i = 1'b0;
    bus.x0_i = '0; bus.y0_i = '0; bus.z0_i = '0;
    kgain = 1.0;
    for (int i = 0; i < IT; i++) kgain = kgain * $sqrt(1.0 + 2.0 ** (-2.0 * i));

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk("reset.xn", int'(bus.xn_o), 0, 0);
    chk("reset.yn", int'(bus.yn_o), 0, 0);
    chk("reset.zn", int'(bus.zn_o), 0, 0);
    chk("reset.done", int'(bus.done_tick_cordic_o), 0, 0);

    expect_res("z0_zero", 4096, 0, 0, 4);
    start_op(KINV, 16'h0000, 16'h0000);
    wait_done("z0_zero", cyc);
    chk("latency", cyc, IT + 1, 0);

    expect_res("pi_4", 2896, 2896, 0, 4);
    start_op(KINV, 16'h0000, 16'h0C91);
    wait_done("pi_4", cyc);
    chk("latency_pi_4", cyc, IT + 1, 0);

    expect_res("neg_pi_4", 2896, -2896, 0, 4);
    start_op(KINV, 16'h0000, 16'hF36F);
    wait_done("neg_pi_4", cyc);

    expect_res("pi_2", 0, 4096, 0, 6);
    start_op(KINV, 16'h0000, 16'h1922);
    wait_done("pi_2", cyc);

    // Reset five cycles into a rotation: outputs clear, no tick, next op is normal.
    start_op(KINV, 16'h0000, 16'h0C91);
    repeat (4) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    chk("abort.xn", int'(bus.xn_o), 0, 0);
    chk("abort.yn", int'(bus.yn_o), 0, 0);
    chk("abort.zn", int'(bus.zn_o), 0, 0);
    d0 = done_cnt;
    repeat (IT + 5) @(posedge clk);
    #1 chk("abort.no_done", done_cnt, d0, 0);
    expect_res("after_abort", 2896, 2896, 0, 4);
    start_op(KINV, 16'h0000, 16'h0C91);
    wait_done("after_abort", cyc);
    chk("latency_after_abort", cyc, IT + 1, 0);

    // Starts during ROTATE are ignored; then a start right after the done tick.
    expect_res("ignore_start", 2896, 2896, 0, 4);
    start_op(KINV, 16'h0000, 16'h0C91);
    bus.start_cordic_i = 1'b1;
    bus.x0_i = KINV; bus.y0_i = '0; bus.z0_i = 16'hE6DE;
    repeat (3) @(posedge clk);
    #1 bus.start_cordic_i = 1'b0;
    wait_done("ignore_start", cyc);
    expect_res("back_to_back", 2896, -2896, 0, 4);
    start_op(KINV, 16'h0000, 16'hF36F);
    wait_done("back_to_back", cyc);
    chk("latency_back_to_back", cyc, IT + 1, 0);

    // Random angles in [-pi/2, pi/2] against a real-valued model.
    for (int k = 0; k < 8; k++) begin
      z  = int'($urandom_range(0, 12868)) - 6434;
      zr = real'(z) / 4096.0;
      expect_res($sformatf("rand%0d", k),
                 rnd(2487.0 * kgain * $cos(zr)),
                 rnd(2487.0 * kgain * $sin(zr)), 0, 6);
      start_op(KINV, 16'h0000, 16'(z));
      wait_done($sformatf("rand%0d", k), cyc);
    end

    repeat (5) @(posedge clk);
    #1;
    chk("done_count", done_cnt, exp_done, 0);
    chk("scoreboard_empty", sb.size(), 0, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
